robot_nav: RTL

- Parametrised successor to the single-sensor robot controller.
- Takes N_SENS registered distance channels and debounces obstacle detection on the centre channel.
- Chooses a turn direction from the side channels, with a reverse-escape mode when both sides are blocked.
- Drives the left/right motor command and speed outputs. Sits between the sensor front-end and the motor PWM block.

---
 rtl/robot_nav.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/robot_nav.sv
// Obstacle-avoiding navigation controller: debounces the centre distance channel, picks a
// turn side from the outer channels and drives motor/speed commands. Optional ramp: ROBOT_NAV_SPEED_RAMP_EN.
module robot_nav #(
  parameter int N_SENS      = 3,
  parameter int DIST_W      = 16,
  parameter int STOP_DIST   = 100,
  parameter int SIDE_DIST   = 150,
  parameter int DEBOUNCE    = 3,
  parameter int TURN_CYCLES = 8,
  parameter int REV_CYCLES  = 4,
  parameter int SPD_W       = 8,
  parameter int MAX_SPD     = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [N_SENS*DIST_W-1:0] dist_v,
  input  logic                     dist_valid,
  output logic [1:0]               mot_l,
  output logic [1:0]               mot_r,
  output logic [SPD_W-1:0]         speed,
  output logic [2:0]               state_o,
  output logic                     obst
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FWD     = 3'd1,
    S_BRAKE   = 3'd2,
    S_TURN_L  = 3'd3,
    S_TURN_R  = 3'd4,
    S_REVERSE = 3'd5
  } state_t;

  localparam int TMR_MAX = (TURN_CYCLES > REV_CYCLES) ? TURN_CYCLES : REV_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);
  localparam int CENTRE  = N_SENS / 2;

  localparam logic [CNT_W-1:0]  DEB_C    = CNT_W'(DEBOUNCE);
  localparam logic [TMR_W-1:0]  TURN_C   = TMR_W'(TURN_CYCLES);
  localparam logic [TMR_W-1:0]  REV_C    = TMR_W'(REV_CYCLES);
  localparam logic [DIST_W-1:0] STOP_D   = DIST_W'(STOP_DIST);
  localparam logic [DIST_W-1:0] SIDE_D   = DIST_W'(SIDE_DIST);
  localparam logic [SPD_W-1:0]  SPD_FULL = SPD_W'(MAX_SPD);
  localparam logic [SPD_W-1:0]  SPD_HALF = SPD_W'(MAX_SPD / 2);

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [DIST_W-1:0]  lat_l, lat_l_nx, lat_r, lat_r_nx;
  logic [DIST_W-1:0]  ch_l, ch_c, ch_r;
  logic               centre_near, lat_l_blk, lat_r_blk;
  logic [1:0]         mot_l_nx, mot_r_nx;
  logic [SPD_W-1:0]   spd_target, speed_nx;
  logic               unused_reserved_ch;

  // Only the outer and centre channels steer; the rest are reserved but still folded here.
  assign ch_l = dist_v[0 +: DIST_W];
  assign ch_c = dist_v[CENTRE*DIST_W +: DIST_W];
  assign ch_r = dist_v[(N_SENS-1)*DIST_W +: DIST_W];
  assign unused_reserved_ch = ^dist_v;

  // A zero reading is a sensor fault and is treated as an obstacle.
  assign centre_near = (ch_c == '0) || (ch_c < STOP_D);
  assign lat_l_blk   = (lat_l == '0) || (lat_l < SIDE_D);
  assign lat_r_blk   = (lat_r == '0) || (lat_r < SIDE_D);
  assign cnt_inc     = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      tmr   <= '0;
      lat_l <= '0;
      lat_r <= '0;
      mot_l <= M_STOP;
      mot_r <= M_STOP;
      speed <= '0;
      obst  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tmr   <= tmr_nx;
      lat_l <= lat_l_nx;
      lat_r <= lat_r_nx;
      mot_l <= mot_l_nx;
      mot_r <= mot_r_nx;
      speed <= speed_nx;
      obst  <= (cnt_nx != '0);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tmr_nx   = tmr;
    lat_l_nx = lat_l;
    lat_r_nx = lat_r;
    if (!run) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      tmr_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nx = S_FWD;
          cnt_nx   = '0;
          tmr_nx   = '0;
        end
        S_FWD: begin
          if (dist_valid) begin
            if (!centre_near) begin
              cnt_nx = '0;
            end else if (cnt_inc >= DEB_C) begin
              // Snapshot the side channels from the sample that confirmed the obstacle.
              state_nx = S_BRAKE;
              cnt_nx   = '0;
              lat_l_nx = ch_l;
              lat_r_nx = ch_r;
            end else begin
              cnt_nx = cnt_inc;
            end
          end
        end
        S_BRAKE: begin
          tmr_nx = TMR_W'(1);
          if (lat_l_blk && lat_r_blk)
            state_nx = S_REVERSE;
          else if (lat_l >= lat_r)
            state_nx = S_TURN_L;
          else
            state_nx = S_TURN_R;
        end
        S_TURN_L, S_TURN_R: begin
          if (tmr == TURN_C) begin
            state_nx = S_FWD;
            tmr_nx   = '0;
            cnt_nx   = '0;
          end else begin
            tmr_nx = tmr + TMR_W'(1);
          end
        end
        S_REVERSE: begin
          if (tmr == REV_C) begin
            state_nx = S_TURN_L;
            tmr_nx   = TMR_W'(1);
          end else begin
            tmr_nx = tmr + TMR_W'(1);
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          tmr_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    mot_l_nx   = M_STOP;
    mot_r_nx   = M_STOP;
    spd_target = '0;
    unique case (state_nx)
      S_FWD: begin
        mot_l_nx   = M_FWD;
        mot_r_nx   = M_FWD;
        spd_target = SPD_FULL;
      end
      S_TURN_L: begin
        mot_l_nx   = M_REV;
        mot_r_nx   = M_FWD;
        spd_target = SPD_HALF;
      end
      S_TURN_R: begin
        mot_l_nx   = M_FWD;
        mot_r_nx   = M_REV;
        spd_target = SPD_HALF;
      end
      S_REVERSE: begin
        mot_l_nx   = M_REV;
        mot_r_nx   = M_REV;
        spd_target = SPD_HALF;
      end
      default: begin
        mot_l_nx   = M_STOP;
        mot_r_nx   = M_STOP;
        spd_target = '0;
      end
    endcase
  end

`ifdef ROBOT_NAV_SPEED_RAMP_EN
  // Every state change restarts the ramp; zero-speed states land on 0 at once.
  always_comb begin
    speed_nx = '0;
    if (state_nx != state)
      speed_nx = '0;
    else if (speed < spd_target)
      speed_nx = speed + SPD_W'(1);
    else
      speed_nx = spd_target;
  end
`else
  assign speed_nx = spd_target;
`endif

  assign state_o = state;

endmodule
